// File: rtl/ifft_output_reorder.sv
// Output reorder buffer for the 64-point SDF IFFT.
// Bit-reversed frames in, natural-order stream out via a ping-pong RAM.
module ifft_output_reorder #(
    parameter  int INTEGER_SIZE = 6,
    parameter  int FRACT_SIZE   = 12,
    parameter  int NFFT         = 64,
    localparam int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE,
    localparam int ADDR_W       = $clog2(NFFT)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_conv,
    input  logic signed [DATA_WIDTH-1:0] serial_in_r,
    input  logic signed [DATA_WIDTH-1:0] serial_in_i,
    output logic signed [DATA_WIDTH-1:0] serial_out_r,
    output logic signed [DATA_WIDTH-1:0] serial_out_i,
    output logic                         out_valid,
    output logic                         out_first,
    output logic                         out_last,
    output logic        [ADDR_W-1:0]     out_index
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NFFT - 1);

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    state_t                  r_state;
    logic                    r_wr_bank;
    logic [ADDR_W-1:0]       r_wr_cnt;
    logic                    r_full;
    logic                    r_full_bank;

    logic                    r_rd_act;
    logic                    r_rd_bank;
    logic [ADDR_W-1:0]       r_rd_cnt;
    logic                    r_s1_vld;
    logic [ADDR_W-1:0]       r_s1_idx;

    logic [2*DATA_WIDTH-1:0] r_mem [0:2*NFFT-1];
    logic [2*DATA_WIDTH-1:0] r_rd_data;

    logic                    w_wr_en;
    logic [ADDR_W:0]         w_wr_addr;
    logic [ADDR_W:0]         w_rd_addr;

    // In IDLE wr_cnt is always 0, so the same address path serves sample 0.
    assign w_wr_en   = (r_state == S_WRITE) || start_conv;
    assign w_wr_addr = {r_wr_bank, bitrev(r_wr_cnt)};
    assign w_rd_addr = r_full ? {r_full_bank, {ADDR_W{1'b0}}}
                              : {r_rd_bank, r_rd_cnt};

    // Writer FSM: counts a frame in and flags the bank full on its last sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_full      <= 1'b0;
            r_full_bank <= 1'b0;
        end else begin
            r_full <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start_conv) begin
                        r_wr_cnt <= ADDR_W'(1);
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (r_wr_cnt == LAST) begin
                        r_full      <= 1'b1;
                        r_full_bank <= r_wr_bank;
                        r_wr_bank   <= ~r_wr_bank;
                        r_wr_cnt    <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    // Ping-pong RAM: contents are never reset; read is registered.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= {serial_in_r, serial_in_i};
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Reader: a freshly filled bank restarts the sweep at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_act  <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_cnt  <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_idx  <= '0;
        end else if (r_full) begin
            r_rd_act  <= 1'b1;
            r_rd_bank <= r_full_bank;
            r_rd_cnt  <= ADDR_W'(1);
            r_s1_vld  <= 1'b1;
            r_s1_idx  <= '0;
        end else if (r_rd_act) begin
            r_s1_vld <= 1'b1;
            r_s1_idx <= r_rd_cnt;
            r_rd_cnt <= r_rd_cnt + ADDR_W'(1);
            if (r_rd_cnt == LAST) begin
                r_rd_act <= 1'b0;
            end
        end else begin
            r_s1_vld <= 1'b0;
        end
    end

    // Output register: everything forced to zero when not valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_first    <= 1'b0;
            out_last     <= 1'b0;
            out_index    <= '0;
            serial_out_r <= '0;
            serial_out_i <= '0;
        end else begin
            out_valid    <= r_s1_vld;
            out_first    <= r_s1_vld && (r_s1_idx == '0);
            out_last     <= r_s1_vld && (r_s1_idx == LAST);
            out_index    <= r_s1_vld ? r_s1_idx : '0;
            serial_out_r <= r_s1_vld ? r_rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
            serial_out_i <= r_s1_vld ? r_rd_data[DATA_WIDTH-1:0] : '0;
        end
    end

endmodule

// File: tb/tb_ifft_output_reorder.sv
// Directed bench for ifft_output_reorder.
// Per-cycle expected stream plus hand-computed spot values.
module tb_ifft_output_reorder;

    localparam int DW   = 18;
    localparam int N    = 64;
    localparam int AW   = 6;
    localparam int OW   = 3 + AW + 2 * DW;
    localparam int MAXC = 400;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start_conv = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic                 out_valid;
    logic                 out_first;
    logic                 out_last;
    logic [AW-1:0]        out_index;
    logic [OW-1:0]        w_obs;

    int n_total = 0;
    int n_pass  = 0;

    logic          st_s  [MAXC];
    logic [DW-1:0] st_r  [MAXC];
    logic [DW-1:0] st_i  [MAXC];
    logic [OW-1:0] exp_w [MAXC];
    logic [OW-1:0] obs_w [MAXC];
    logic [DW-1:0] fr_r  [N];
    logic [DW-1:0] fr_i  [N];

    ifft_output_reorder dut (
        .clk          (clk),
        .rst          (rst),
        .start_conv   (start_conv),
        .serial_in_r  (in_r),
        .serial_in_i  (in_i),
        .serial_out_r (out_r),
        .serial_out_i (out_i),
        .out_valid    (out_valid),
        .out_first    (out_first),
        .out_last     (out_last),
        .out_index    (out_index)
    );

    assign w_obs = {out_valid, out_first, out_last, out_index, out_r, out_i};

    always #5 clk = ~clk;

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < AW; b++) begin
            r = r | (((k >> b) & 1) << (AW - 1 - b));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic clear_plan();
        for (int c = 0; c < MAXC; c++) begin
            st_s[c]  = 1'b0;
            st_r[c]  = '0;
            st_i[c]  = '0;
            exp_w[c] = '0;
            obs_w[c] = '0;
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < N; k++) begin
            fr_r[k] = DW'(k);
            fr_i[k] = DW'(-k);
        end
    endtask

    task automatic plan(input int t);
        int k;
        st_s[t] = 1'b1;
        for (int j = 0; j < N; j++) begin
            st_r[t+j] = fr_r[j];
            st_i[t+j] = fr_i[j];
        end
        for (int n = 0; n < N; n++) begin
            k = brev(n);
            exp_w[t+N+1+n] = {1'b1, n == 0, n == N - 1, AW'(n), fr_r[k], fr_i[k]};
        end
    endtask

    task automatic run(input string name, input int len);
        for (int c = 0; c < len; c++) begin
            start_conv = st_s[c];
            in_r       = st_r[c];
            in_i       = st_i[c];
            @(posedge clk);
            #1;
            obs_w[c] = w_obs;
            check($sformatf("%s_cyc%0d", name, c), 64'(w_obs), 64'(exp_w[c]));
        end
        start_conv = 1'b0;
        in_r       = '0;
        in_i       = '0;
    endtask

    function automatic int count_valid(input int a, input int b);
        int n;
        n = 0;
        for (int c = a; c <= b; c++) begin
            n += int'(obs_w[c][OW-1]);
        end
        return n;
    endfunction

    initial begin
        // Reset state
        #1;
        check("reset_async", 64'(w_obs), 64'd0);
        @(posedge clk);
        #1;
        check("reset_held", 64'(w_obs), 64'd0);
        #3;
        rst = 1'b1;

        // Single frame at t=10
        clear_plan();
        set_ramp();
        plan(10);
        run("single", 150);
        check("s_first", 64'(obs_w[75]),
              64'({1'b1, 1'b1, 1'b0, 6'd0, 18'd0, 18'd0}));
        check("s_idx1", 64'(obs_w[76]),
              64'({1'b1, 1'b0, 1'b0, 6'd1, 18'd32, 18'h3FFE0}));
        check("s_idx2", 64'(obs_w[77]),
              64'({1'b1, 1'b0, 1'b0, 6'd2, 18'd16, 18'h3FFF0}));
        check("s_idx3", 64'(obs_w[78]),
              64'({1'b1, 1'b0, 1'b0, 6'd3, 18'd48, 18'h3FFD0}));
        check("s_last", 64'(obs_w[138]),
              64'({1'b1, 1'b0, 1'b1, 6'd63, 18'd63, 18'h3FFC1}));
        check("s_before", 64'(obs_w[74]), 64'd0);
        check("s_after", 64'(obs_w[139]), 64'd0);

        // Extra start at wr_cnt=20 is ignored
        clear_plan();
        set_ramp();
        plan(10);
        st_s[30] = 1'b1;
        run("ignored", 150);
        check("ign_idx1", 64'(obs_w[76]),
              64'({1'b1, 1'b0, 1'b0, 6'd1, 18'd32, 18'h3FFE0}));
        check("ign_cnt", 64'(count_valid(0, 149)), 64'd64);

        // Three back-to-back frames
        clear_plan();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                fr_r[k] = DW'(100 * f + k);
                fr_i[k] = DW'(-(1000 * f) - 3 * k);
            end
            plan(5 + N * f);
        end
        run("b2b", 270);
        check("b2b_cnt", 64'(count_valid(0, 269)), 64'd192);
        check("b2b_l0", 64'(obs_w[133][OW-1 -: 3]), 64'd5);
        check("b2b_f1", 64'(obs_w[134][OW-1 -: 3]), 64'd6);
        check("b2b_l1", 64'(obs_w[197][OW-1 -: 3]), 64'd5);
        check("b2b_f2", 64'(obs_w[198][OW-1 -: 3]), 64'd6);

        // Signed extremes
        clear_plan();
        set_ramp();
        fr_r[1] = 18'h20000;
        fr_i[1] = 18'h1FFFF;
        fr_r[2] = 18'h1FFFF;
        fr_i[2] = 18'h20000;
        plan(10);
        run("ext", 150);
        check("ext_idx32", 64'(obs_w[107]),
              64'({1'b1, 1'b0, 1'b0, 6'd32, 18'h20000, 18'h1FFFF}));
        check("ext_idx16", 64'(obs_w[91]),
              64'({1'b1, 1'b0, 1'b0, 6'd16, 18'h1FFFF, 18'h20000}));

        // Gap of 10 cycles between output frames
        clear_plan();
        set_ramp();
        plan(5);
        for (int k = 0; k < N; k++) begin
            fr_r[k] = DW'(500 + k);
            fr_i[k] = DW'(200 + k);
        end
        plan(79);
        run("gap", 220);
        check("gap_last", 64'(obs_w[133][OW-1 -: 3]), 64'd5);
        check("gap_zero", 64'(count_valid(134, 143)), 64'd0);
        check("gap_first", 64'(obs_w[144][OW-1 -: 3]), 64'd6);

        // Reset while index 30 is on the output
        clear_plan();
        set_ramp();
        plan(5);
        run("rstmid", 100);
        @(posedge clk);
        #1;
        check("rst_idx30", 64'(w_obs),
              64'({1'b1, 1'b0, 1'b0, 6'd30, 18'd30, 18'h3FFE2}));
        #2;
        rst = 1'b0;
        #1;
        check("rst_zero", 64'(w_obs), 64'd0);
        #1;
        rst = 1'b1;
        clear_plan();
        run("rst_idle", 80);
        check("rst_idle_cnt", 64'(count_valid(0, 79)), 64'd0);
        clear_plan();
        set_ramp();
        plan(3);
        run("rst_new", 140);
        check("rst_new_first", 64'(obs_w[68][OW-1 -: 3]), 64'd6);
        check("rst_new_pre", 64'(count_valid(0, 67)), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
